// File: rtl/csi_raw10_pkg.sv
// Shared RAW10 constants and the 4-pixel group byte packer used by both the
// transmit packer and the receive-side unpacker.
package csi_raw10_pkg;

   localparam int unsigned BYTES_PER_GROUP = 5;
   localparam int unsigned PIX_PER_GROUP   = 4;
   localparam int unsigned PIX_W           = 10;
   localparam int unsigned GROUP_W         = PIX_PER_GROUP * PIX_W;
   localparam int unsigned CNT_W           = 4;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StFlush
   } pack_state_e;

   // Returns {B4, B3, B2, B1, B0}; B0 is the first byte on the wire.
   function automatic logic [39:0] raw10_pack_group(input logic [39:0] pix);
      logic [PIX_W-1:0] p0, p1, p2, p3;
      p0 = pix[39:30];
      p1 = pix[29:20];
      p2 = pix[19:10];
      p3 = pix[9:0];
      return {p3[1:0], p2[1:0], p1[1:0], p0[1:0], p3[9:2], p2[9:2], p1[9:2], p0[9:2]};
   endfunction

   function automatic logic [3:0] keep_mask(input logic [CNT_W-1:0] cnt);
      logic [3:0] mask;
      case (cnt)
         CNT_W'(0): mask = 4'b0000;
         CNT_W'(1): mask = 4'b0001;
         CNT_W'(2): mask = 4'b0011;
         CNT_W'(3): mask = 4'b0111;
         default:   mask = 4'b1111;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/raw10_byte_fifo.sv
// Byte shift buffer: appends 5 bytes per push, removes up to 4 oldest bytes per pop.
// Bytes above the fill level are always zero, so the head word needs no masking.
module raw10_byte_fifo
   import csi_raw10_pkg::*;
#(
   parameter int unsigned MAX_BYTES = 9
) (
   input  logic                          clk_i,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          push,
   input  logic                          pop,
   input  logic [8*BYTES_PER_GROUP-1:0]  push_bytes,
   output logic [CNT_W-1:0]              count,
   output logic [CNT_W-1:0]              count_next,
   output logic [31:0]                   head
);

   localparam int unsigned DATA_W = 8 * MAX_BYTES;

   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] data_next;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] push_ext;
   logic [CNT_W-1:0]  base;

   always_comb begin
      shifted = pop ? (data >> 32) : data;
      if (!pop) begin
         base = count;
      end else if (count >= CNT_W'(4)) begin
         base = count - CNT_W'(4);
      end else begin
         base = '0;
      end
      push_ext = '0;
      push_ext[8*BYTES_PER_GROUP-1:0] = push_bytes;
      // New bytes land directly above whatever survives the pop.
      data_next  = push ? (shifted | (push_ext << {base, 3'b000})) : shifted;
      count_next = base + (push ? CNT_W'(BYTES_PER_GROUP) : '0);
      if (clear) begin
         data_next  = '0;
         count_next = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         data  <= '0;
         count <= '0;
      end else begin
         data  <= data_next;
         count <= count_next;
      end
   end

   assign head = data[31:0];

endmodule

// File: rtl/mipi_tx_raw10_pack.sv
// RAW10 group packer: turns 4-pixel groups into CSI-2 RAW10 bytes emitted as
// 32-bit little-endian words, with per-line flush and word counting.
module mipi_tx_raw10_pack
   import csi_raw10_pkg::*;
#(
   parameter int unsigned MAX_BYTES = 9
) (
   input  logic                clk_i,
   input  logic                reset,
   input  logic                clear_i,
   input  logic                pix_valid_i,
   output logic                pix_ready_o,
   input  logic [GROUP_W-1:0]  pix_i,
   input  logic                pix_last_i,
   output logic                word_valid_o,
   input  logic                word_ready_i,
   output logic [31:0]         word_o,
   output logic [3:0]          word_keep_o,
   output logic                word_last_o,
   output logic [15:0]         line_words_o
);

   pack_state_e      state;
   pack_state_e      state_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [15:0]      word_cnt;
   logic             flushing;
   logic             flush_next;
   logic             push;
   logic             pop;
   logic             final_pop;

   raw10_byte_fifo #(
      .MAX_BYTES (MAX_BYTES)
   ) u_fifo (
      .clk_i      (clk_i),
      .reset      (reset),
      .clear      (clear_i),
      .push       (push),
      .pop        (pop),
      .push_bytes (raw10_pack_group(pix_i)),
      .count      (count),
      .count_next (count_next),
      .head       (word_o)
   );

   assign flushing = (state == StFlush);

   always_comb begin
      // Accepting alongside a pop lets the pipeline run without bubbles mid-line.
      pix_ready_o = !flushing && ((count <= CNT_W'(3)) ||
                    ((count <= CNT_W'(7)) && word_valid_o && word_ready_i));
      push        = pix_valid_i && pix_ready_o && !clear_i;
      pop         = word_valid_o && word_ready_i && !clear_i;
      final_pop   = pop && word_last_o;
   end

   always_comb begin
      state_next = state;
      if (clear_i) begin
         state_next = StIdle;
      end else if (push && pix_last_i) begin
         state_next = StFlush;
      end else if (final_pop) begin
         state_next = StIdle;
      end else if (state != StFlush) begin
         state_next = (count_next != '0) ? StFill : StIdle;
      end
      flush_next = (state_next == StFlush);
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state        <= StIdle;
         word_valid_o <= 1'b0;
         word_keep_o  <= 4'b0000;
         word_last_o  <= 1'b0;
         word_cnt     <= '0;
         line_words_o <= '0;
      end else begin
         state        <= state_next;
         word_valid_o <= (count_next >= CNT_W'(4)) || (flush_next && (count_next != '0));
         word_keep_o  <= keep_mask(count_next);
         word_last_o  <= flush_next && (count_next != '0) && (count_next <= CNT_W'(4));
         if (clear_i) begin
            word_cnt <= '0;
         end else if (final_pop) begin
            line_words_o <= word_cnt + 16'd1;
            word_cnt     <= '0;
         end else if (pop) begin
            word_cnt <= word_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mipi_tx_raw10_pack.sv
// Directed self-checking bench for the RAW10 word packer.
module tb_mipi_tx_raw10_pack;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        pix_valid;
   logic        pix_ready;
   logic [39:0] pix;
   logic        pix_last;
   logic        word_valid;
   logic        word_ready;
   logic [31:0] word;
   logic [3:0]  word_keep;
   logic        word_last;
   logic [15:0] line_words;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] w;
      logic [3:0]  k;
      logic        l;
      int          cyc;
   } cap_t;

   cap_t       cap[$];
   logic [7:0] exp_q[$];
   int         cyc = 0;
   int         mcount = 0;
   int         ready_at8 = 0;
   int         unstable = 0;
   logic       stall_prev = 1'b0;
   logic [31:0] pw;
   logic [3:0]  pk;
   logic        pl;

   mipi_tx_raw10_pack dut (
      .clk_i        (clk),
      .reset        (reset),
      .clear_i      (clear),
      .pix_valid_i  (pix_valid),
      .pix_ready_o  (pix_ready),
      .pix_i        (pix),
      .pix_last_i   (pix_last),
      .word_valid_o (word_valid),
      .word_ready_i (word_ready),
      .word_o       (word),
      .word_keep_o  (word_keep),
      .word_last_o  (word_last),
      .line_words_o (line_words)
   );

   always #5 clk = ~clk;

   // Observer: records handshaken words and tracks the buffer fill level.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset || clear) begin
         mcount     <= 0;
         stall_prev <= 1'b0;
      end else begin
         if (word_valid && word_ready) cap.push_back('{word, word_keep, word_last, cyc});
         if (mcount == 8 && pix_ready) ready_at8 <= ready_at8 + 1;
         if (stall_prev && (word !== pw || word_keep !== pk || word_last !== pl))
            unstable <= unstable + 1;
         stall_prev <= word_valid && !word_ready;
         pw <= word;
         pk <= word_keep;
         pl <= word_last;
         mcount <= mcount - ((word_valid && word_ready) ? ((mcount >= 4) ? 4 : mcount) : 0)
                   + ((pix_valid && pix_ready) ? 5 : 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   function automatic void add_exp(input logic [39:0] p);
      exp_q.push_back(p[39:32]);
      exp_q.push_back(p[29:22]);
      exp_q.push_back(p[19:12]);
      exp_q.push_back(p[9:2]);
      exp_q.push_back({p[1:0], p[11:10], p[21:20], p[31:30]});
   endfunction

   function automatic logic [31:0] exp_word(input int i);
      logic [31:0] v = '0;
      for (int b = 0; b < 4; b++)
         if (4 * i + b < exp_q.size()) v[8*b +: 8] = exp_q[4*i+b];
      return v;
   endfunction

   function automatic logic [3:0] exp_keep(input int i);
      int n = exp_q.size() - 4 * i;
      if (n >= 4) return 4'b1111;
      if (n == 3) return 4'b0111;
      if (n == 2) return 4'b0011;
      return 4'b0001;
   endfunction

   function automatic logic [39:0] grp(input int i);
      logic [39:0] base_v = 40'hA5C396F01E;
      return base_v ^ (40'(i) * 40'h13579BDF11);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_group(input logic [39:0] p, input logic l);
      logic acc = 1'b0;
      pix = p;
      pix_last = l;
      pix_valid = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
         #1;
         acc = pix_ready;
         tick();
      end
      pix_valid = 1'b0;
      pix_last = 1'b0;
      add_exp(p);
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout: got no acceptance want acceptance of %h", p);
      end
   endtask

   task automatic wait_words(input int want);
      for (int n = 0; n < 300 && cap.size() < want; n++) tick();
      tick();
   endtask

   task automatic check_stream(input string name);
      int nw = (exp_q.size() + 3) / 4;
      checks++;
      if (cap.size() != nw) begin
         errors++;
         $display("FAIL %s_count: got %0d words want %0d", name, cap.size(), nw);
      end
      for (int i = 0; i < cap.size(); i++) begin
         checks++;
         if (cap[i].w !== exp_word(i) || cap[i].k !== exp_keep(i) || cap[i].l !== (i == nw - 1)) begin
            errors++;
            $display("FAIL %s_word%0d: got %h/%b/%b want %h/%b/%b", name, i, cap[i].w, cap[i].k,
                     cap[i].l, exp_word(i), exp_keep(i), (i == nw - 1));
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; clear = 1'b0; pix_valid = 1'b0; pix = '0; pix_last = 1'b0; word_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if ({word_valid, word, word_keep, word_last, line_words} !== 54'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b w=%h k=%b l=%b lw=%0d want all zero",
                  word_valid, word, word_keep, word_last, line_words);
      end
      checks++;
      if (pix_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", pix_ready);
      end
      tick();
   endtask

   task automatic test_single_group();
      cap.delete(); exp_q.delete();
      word_ready = 1'b1;
      send_group({10'h3FF, 10'h000, 10'h2AA, 10'h155}, 1'b1);
      wait_words(2);
      checks++;
      if (cap.size() != 2) begin
         errors++;
         $display("FAIL single_count: got %0d want 2", cap.size());
      end else begin
         checks++;
         if (cap[0].w !== 32'h55AA00FF || cap[0].k !== 4'b1111 || cap[0].l !== 1'b0) begin
            errors++;
            $display("FAIL single_w0: got %h/%b/%b want 55aa00ff/1111/0", cap[0].w, cap[0].k, cap[0].l);
         end
         checks++;
         if (cap[1].w !== 32'h00000063 || cap[1].k !== 4'b0001 || cap[1].l !== 1'b1) begin
            errors++;
            $display("FAIL single_w1: got %h/%b/%b want 00000063/0001/1", cap[1].w, cap[1].k, cap[1].l);
         end
      end
      checks++;
      if (line_words !== 16'd2) begin
         errors++;
         $display("FAIL single_line_words: got %0d want 2", line_words);
      end
   endtask

   task automatic test_back_to_back();
      cap.delete(); exp_q.delete();
      word_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_group(grp(i), i == 3);
      wait_words(5);
      check_stream("b2b");
      checks++;
      if (cap.size() != 5 || cap[4].cyc - cap[0].cyc != 4) begin
         errors++;
         $display("FAIL b2b_consecutive: got %0d words spanning %0d cycles want 5 in 4",
                  cap.size(), (cap.size() > 0) ? cap[cap.size()-1].cyc - cap[0].cyc : -1);
      end
      checks++;
      if (line_words !== 16'd5) begin
         errors++;
         $display("FAIL b2b_line_words: got %0d want 5", line_words);
      end
   endtask

   task automatic test_backpressure();
      cap.delete(); exp_q.delete();
      ready_at8 = 0;
      unstable = 0;
      word_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 8; i++) send_group(grp(10 + i), i == 7);
         end
         begin
            repeat (40) begin
               word_ready = !word_ready;
               tick();
            end
         end
      join
      word_ready = 1'b1;
      wait_words(10);
      check_stream("bp");
      checks++;
      if (line_words !== 16'd10) begin
         errors++;
         $display("FAIL bp_line_words: got %0d want 10", line_words);
      end
      checks++;
      if (ready_at8 != 0) begin
         errors++;
         $display("FAIL bp_ready_at_8: got %0d cycles want 0", ready_at8);
      end
      checks++;
      if (unstable != 0) begin
         errors++;
         $display("FAIL bp_stall_stable: got %0d changes want 0", unstable);
      end
   endtask

   task automatic test_push_pop_at_7();
      cap.delete(); exp_q.delete();
      word_ready = 1'b0;
      send_group(grp(20), 1'b0);          // 5
      word_ready = 1'b1; tick();          // 1
      word_ready = 1'b0;
      send_group(grp(21), 1'b0);          // 6
      word_ready = 1'b1; tick();          // 2
      word_ready = 1'b0;
      send_group(grp(22), 1'b0);          // 7
      word_ready = 1'b1;
      pix = grp(23); pix_last = 1'b1; pix_valid = 1'b1;
      #1;
      checks++;
      if (pix_ready !== 1'b1) begin
         errors++;
         $display("FAIL pp7_ready: got %b want 1", pix_ready);
      end
      add_exp(grp(23));
      tick();                             // push+pop: 8
      pix_valid = 1'b0; pix_last = 1'b0; word_ready = 1'b0;
      #1;
      checks++;
      if (pix_ready !== 1'b0 || word_valid !== 1'b1 || word_keep !== 4'b1111 || word_last !== 1'b0) begin
         errors++;
         $display("FAIL pp7_at8: got r=%b v=%b k=%b l=%b want 0/1/1111/0",
                  pix_ready, word_valid, word_keep, word_last);
      end
      tick();
      word_ready = 1'b1;
      wait_words(5);
      check_stream("pp7");
      checks++;
      if (line_words !== 16'd5) begin
         errors++;
         $display("FAIL pp7_line_words: got %0d want 5", line_words);
      end
   endtask

   task automatic test_clear_flush();
      cap.delete(); exp_q.delete();
      word_ready = 1'b0;
      send_group(grp(30), 1'b0);
      word_ready = 1'b1; tick();
      word_ready = 1'b0;
      send_group(grp(31), 1'b0);
      word_ready = 1'b1; tick();
      word_ready = 1'b0;
      send_group(grp(32), 1'b1);
      word_ready = 1'b1; tick();          // 3 bytes left, flushing
      checks++;
      if (word_valid !== 1'b1 || word_keep !== 4'b0111 || word_last !== 1'b1) begin
         errors++;
         $display("FAIL clr_pre: got v=%b k=%b l=%b want 1/0111/1", word_valid, word_keep, word_last);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      #1;
      checks++;
      if (word_valid !== 1'b0 || pix_ready !== 1'b1 || word_last !== 1'b0 || line_words !== 16'd5) begin
         errors++;
         $display("FAIL clr_post: got v=%b r=%b l=%b lw=%0d want 0/1/0/5",
                  word_valid, pix_ready, word_last, line_words);
      end
      repeat (5) tick();
      checks++;
      if (cap.size() != 3 || cap[0].w !== exp_word(0) || cap[1].w !== exp_word(1) ||
          cap[2].w !== exp_word(2)) begin
         errors++;
         $display("FAIL clr_words: got %0d words want 3 matching", cap.size());
      end
      for (int i = 0; i < cap.size(); i++) begin
         checks++;
         if (cap[i].l !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_last%0d: got %b want 0", i, cap[i].l);
         end
      end
      checks++;
      if (line_words !== 16'd5) begin
         errors++;
         $display("FAIL clr_line_words: got %0d want 5", line_words);
      end
   endtask

   task automatic test_reset_mid_line();
      cap.delete(); exp_q.delete();
      word_ready = 1'b0;
      send_group(grp(40), 1'b0);
      word_ready = 1'b1; tick();
      word_ready = 1'b0;
      send_group(grp(41), 1'b0);          // 6 bytes buffered
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({word_valid, word, word_keep, word_last, line_words} !== 54'd0 || pix_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid: got v=%b w=%h k=%b l=%b lw=%0d r=%b want zeros and ready",
                  word_valid, word, word_keep, word_last, line_words, pix_ready);
      end
      cap.delete(); exp_q.delete();
      word_ready = 1'b1;
      send_group({10'h3FF, 10'h000, 10'h2AA, 10'h155}, 1'b1);
      wait_words(2);
      checks++;
      if (cap.size() != 2 || cap[0].w !== 32'h55AA00FF || cap[1].w !== 32'h00000063 ||
          cap[1].l !== 1'b1 || line_words !== 16'd2) begin
         errors++;
         $display("FAIL rst_next_line: got %0d words lw=%0d want 55aa00ff,00000063 lw=2",
                  cap.size(), line_words);
      end
   endtask

   initial begin
      test_reset();
      test_single_group();
      test_back_to_back();
      test_backpressure();
      test_push_pop_at_7();
      test_clear_flush();
      test_reset_mid_line();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
